// File: rtl/uart_rx_oversampled.sv
// ============================================================================
// Module      : uart_rx_oversampled
// Description : 8-bit UART receiver, oversampled with 3-sample majority vote.
//               Optional even-parity stage enabled by macro UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_oversampled #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  localparam int c_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int c_TW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int c_SW  = $clog2(OVERSAMPLE);

  localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(c_DIV - 1);
  localparam logic [c_SW-1:0] c_SAMP_LAST = c_SW'(OVERSAMPLE - 1);
  localparam logic [c_SW-1:0] c_SAMP_A    = c_SW'(OVERSAMPLE / 2 - 1);
  localparam logic [c_SW-1:0] c_SAMP_B    = c_SW'(OVERSAMPLE / 2);
  localparam logic [c_SW-1:0] c_SAMP_C    = c_SW'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [2:0]      arm_q;
  logic [c_TW-1:0] tick_cnt_q;
  logic [c_SW-1:0] samp_cnt_q, samp_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [1:0]      smp_q, smp_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic            par_err_q, par_err_d;
  logic            perr_q, perr_d;
`endif

  logic w_tick, w_fall, w_decide, w_bit_end, w_maj;

  // arm_q keeps the reset value of the synchronizer from posing as a falling edge
  assign w_fall    = arm_q[2] & rx_prev_q & ~rx_sync_q;
  assign w_tick    = (tick_cnt_q == c_TICK_LAST);
  assign w_decide  = w_tick && (samp_cnt_q == c_SAMP_C);
  assign w_bit_end = w_tick && (samp_cnt_q == c_SAMP_LAST);
  assign w_maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync_q) | (smp_q[1] & rx_sync_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      arm_q     <= 3'b000;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      arm_q     <= {arm_q[1:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if ((state_q == S_IDLE && w_fall) || w_tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      smp_q      <= 2'b11;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      smp_q      <= smp_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= par_err_d;
      perr_q     <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    smp_d      = smp_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d  = par_err_q;
    perr_d     = 1'b0;
`endif

    // The first two votes are stored; the third is the live sample at decision time
    if (state_q != S_IDLE && w_tick) begin
      samp_cnt_d = w_bit_end ? '0 : samp_cnt_q + 1'b1;
      if (samp_cnt_q == c_SAMP_A) smp_d[0] = rx_sync_q;
      if (samp_cnt_q == c_SAMP_B) smp_d[1] = rx_sync_q;
    end

    case (state_q)
      S_IDLE: begin
        if (w_fall) begin
          state_d    = S_START;
          samp_cnt_d = '0;
          bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
          par_err_d  = 1'b0;
`endif
        end
      end
      S_START: begin
        if (w_decide && w_maj) begin
          state_d = S_IDLE;
        end else if (w_bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_decide) shift_d = {w_maj, shift_q[7:1]};
        if (w_bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_decide) par_err_d = ^{shift_q, w_maj};
        if (w_bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Leave at mid-stop so a start edge right after the stop bit is caught
        if (w_decide) begin
          state_d = S_IDLE;
          if (!w_maj) begin
            ferr_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_err_q) begin
            perr_d = 1'b1;
          end
`endif
          else begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
// ============================================================================
// Module      : tb_uart_rx_oversampled
// Description : Directed self-checking bench for uart_rx_oversampled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_oversampled;

  localparam int BIT_CLKS   = 1250;   // 12 MHz / 9600
  localparam int STOP_SHORT = 900;    // stop bit trimmed; decision lands ~762 clks in

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_rx = 1'b0;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_parity_err, o_busy;

  int tests = 0;
  int failed = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_busy = 0, n_overlap = 0;
  logic [7:0] vq[$];

  uart_rx_oversampled dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_valid) begin
      n_valid++;
      vq.push_back(o_data);
    end
    if (o_frame_err) n_ferr++;
    if (o_parity_err) n_perr++;
    if (o_busy) n_busy++;
    if (o_valid && (o_frame_err || o_parity_err)) n_overlap++;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame: start, 8 data LSB first, [parity], stop. glitch_at forces one clk low.
  task automatic send_frame(input logic [7:0] d, input logic par_v, input logic stop_v,
                            input int stop_len, input int glitch_at, input int abort_at);
    logic [10:0] bits;
    int nb;
    int total;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    bits[10]  = par_v;
`ifdef UART_RX_PARITY_EN
    nb        = 11;
    bits[9]   = par_v;
    bits[10]  = stop_v;
`else
    nb        = 10;
    bits[9]   = stop_v;
`endif
    total = (nb - 1) * BIT_CLKS + stop_len;
    for (int c = 0; c < total; c++) begin
      if (c == abort_at) break;
      @(posedge clk);
      #1;
      i_rx = (c == glitch_at) ? 1'b0 : bits[c / BIT_CLKS];
    end
  endtask

  task automatic test_reset();
    int b0;
    i_rx  = 1'b0;
    rst_n = 1'b0;
    wait_clks(5);
    tests++; if (o_data !== 8'h00) begin failed++; $display("FAIL reset_data: got %h want 00", o_data); end
    tests++; if (o_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    tests++; if (o_frame_err !== 1'b0) begin failed++; $display("FAIL reset_ferr: got %b want 0", o_frame_err); end
    tests++; if (o_parity_err !== 1'b0) begin failed++; $display("FAIL reset_perr: got %b want 0", o_parity_err); end
    tests++; if (o_busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    b0 = n_busy;
    rst_n = 1'b1;
    wait_clks(1500);
    tests++; if (n_busy - b0 !== 0) begin failed++; $display("FAIL low_after_reset_busy: got %0d busy cycles want 0", n_busy - b0); end
    tests++; if (n_valid + n_ferr !== 0) begin failed++; $display("FAIL low_after_reset_strobe: got %0d strobes want 0", n_valid + n_ferr); end
    i_rx = 1'b1;
    wait_clks(50);
  endtask

  task automatic test_false_start();
    int v0, f0, b0;
    v0 = n_valid; f0 = n_ferr; b0 = n_busy;
    i_rx = 1'b0;
    wait_clks(200);
    tests++; if (o_busy !== 1'b1) begin failed++; $display("FAIL false_start_busy_high: got %b want 1", o_busy); end
    wait_clks(100);
    i_rx = 1'b1;
    wait_clks(BIT_CLKS);
    tests++; if (o_busy !== 1'b0) begin failed++; $display("FAIL false_start_idle: got busy %b want 0", o_busy); end
    tests++; if ((n_busy - b0 < 700) || (n_busy - b0 > 900)) begin failed++; $display("FAIL false_start_busy_len: got %0d want 700..900", n_busy - b0); end
    tests++; if (n_valid - v0 !== 0) begin failed++; $display("FAIL false_start_valid: got %0d want 0", n_valid - v0); end
    tests++; if (n_ferr - f0 !== 0) begin failed++; $display("FAIL false_start_ferr: got %0d want 0", n_ferr - f0); end
  endtask

  task automatic test_basic();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h61, ^8'h61, 1'b1, STOP_SHORT, -1, -1);
    tests++; if (n_valid - v0 !== 1) begin failed++; $display("FAIL basic_valid_count: got %0d want 1", n_valid - v0); end
    tests++; if (o_data !== 8'h61) begin failed++; $display("FAIL basic_data: got %h want 61", o_data); end
    tests++; if (n_ferr - f0 !== 0) begin failed++; $display("FAIL basic_ferr: got %0d want 0", n_ferr - f0); end
    tests++; if (o_busy !== 1'b0) begin failed++; $display("FAIL basic_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_frame_error();
    int v0, f0, b1;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h00, 1'b0, 1'b0, STOP_SHORT, -1, -1);
    b1 = n_busy;
    wait_clks(1000);
    tests++; if (n_ferr - f0 !== 1) begin failed++; $display("FAIL ferr_count: got %0d want 1", n_ferr - f0); end
    tests++; if (n_valid - v0 !== 0) begin failed++; $display("FAIL ferr_valid: got %0d want 0", n_valid - v0); end
    tests++; if (o_data !== 8'h61) begin failed++; $display("FAIL ferr_data_hold: got %h want 61", o_data); end
    tests++; if (n_busy - b1 !== 0) begin failed++; $display("FAIL ferr_line_low_rearm: got %0d busy cycles want 0", n_busy - b1); end
    i_rx = 1'b1;
    wait_clks(50);
  endtask

  task automatic test_back_to_back();
    int v0, q0;
    v0 = n_valid; q0 = vq.size();
    send_frame(8'h55, ^8'h55, 1'b1, BIT_CLKS, -1, -1);
    send_frame(8'hAA, ^8'hAA, 1'b1, STOP_SHORT, -1, -1);
    tests++; if (n_valid - v0 !== 2) begin failed++; $display("FAIL b2b_count: got %0d want 2", n_valid - v0); end
    if (vq.size() >= q0 + 2) begin
      tests++; if (vq[q0] !== 8'h55) begin failed++; $display("FAIL b2b_first: got %h want 55", vq[q0]); end
      tests++; if (vq[q0+1] !== 8'hAA) begin failed++; $display("FAIL b2b_second: got %h want AA", vq[q0+1]); end
    end else begin
      tests++; failed++; $display("FAIL b2b_capture: got %0d bytes want 2", vq.size() - q0);
    end
  endtask

  task automatic test_glitch_and_reset();
    int v0, f0;
    v0 = n_valid;
    // 3198 = centre vote of frame bit 2 (data bit 1, a '1') after sync latency
    send_frame(8'h5A, ^8'h5A, 1'b1, STOP_SHORT, 3198, -1);
    tests++; if (n_valid - v0 !== 1) begin failed++; $display("FAIL glitch_valid: got %0d want 1", n_valid - v0); end
    tests++; if (o_data !== 8'h5A) begin failed++; $display("FAIL glitch_data: got %h want 5A", o_data); end
    send_frame(8'hC3, ^8'hC3, 1'b1, STOP_SHORT, -1, 4 * BIT_CLKS + 600);
    rst_n = 1'b0;
    i_rx  = 1'b1;
    wait_clks(3);
    tests++; if (o_data !== 8'h00) begin failed++; $display("FAIL midreset_data: got %h want 00", o_data); end
    tests++; if (o_valid !== 1'b0) begin failed++; $display("FAIL midreset_valid: got %b want 0", o_valid); end
    tests++; if (o_frame_err !== 1'b0) begin failed++; $display("FAIL midreset_ferr: got %b want 0", o_frame_err); end
    tests++; if (o_parity_err !== 1'b0) begin failed++; $display("FAIL midreset_perr: got %b want 0", o_parity_err); end
    tests++; if (o_busy !== 1'b0) begin failed++; $display("FAIL midreset_busy: got %b want 0", o_busy); end
    v0 = n_valid; f0 = n_ferr;
    rst_n = 1'b1;
    wait_clks(1300);
    tests++; if ((n_valid - v0) + (n_ferr - f0) !== 0) begin failed++; $display("FAIL midreset_strobe: got %0d want 0", (n_valid - v0) + (n_ferr - f0)); end
    v0 = n_valid;
    send_frame(8'h7A, ^8'h7A, 1'b1, STOP_SHORT, -1, -1);
    tests++; if (n_valid - v0 !== 1) begin failed++; $display("FAIL after_reset_valid: got %0d want 1", n_valid - v0); end
    tests++; if (o_data !== 8'h7A) begin failed++; $display("FAIL after_reset_data: got %h want 7A", o_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int v0, p0;
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h41, 1'b0, 1'b1, STOP_SHORT, -1, -1);
    tests++; if (n_valid - v0 !== 1) begin failed++; $display("FAIL parity_good_valid: got %0d want 1", n_valid - v0); end
    tests++; if (o_data !== 8'h41) begin failed++; $display("FAIL parity_good_data: got %h want 41", o_data); end
    tests++; if (n_perr - p0 !== 0) begin failed++; $display("FAIL parity_good_perr: got %0d want 0", n_perr - p0); end
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h41, 1'b1, 1'b1, STOP_SHORT, -1, -1);
    tests++; if (n_perr - p0 !== 1) begin failed++; $display("FAIL parity_bad_perr: got %0d want 1", n_perr - p0); end
    tests++; if (n_valid - v0 !== 0) begin failed++; $display("FAIL parity_bad_valid: got %0d want 0", n_valid - v0); end
  endtask
`endif

  task automatic test_final();
    tests++; if (n_overlap !== 0) begin failed++; $display("FAIL strobe_overlap: got %0d want 0", n_overlap); end
`ifndef UART_RX_PARITY_EN
    tests++; if (n_perr !== 0) begin failed++; $display("FAIL perr_tied_low: got %0d want 0", n_perr); end
`endif
  endtask

  initial begin
    test_reset();
    test_false_start();
    test_basic();
    test_frame_error();
`ifdef UART_RX_PARITY_EN
    test_parity();
`else
    test_back_to_back();
`endif
    test_glitch_and_reset();
    test_final();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_oversampled.md
UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit; legal values are even, 8 to 16.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port i_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port o_data, output, 8 bits: last good received byte.
REQ-008 SHALL have port o_valid, output, 1 bit: one-cycle strobe marking a new o_data.
REQ-009 SHALL have port o_frame_err, output, 1 bit: one-cycle strobe on a bad stop bit.
REQ-010 SHALL have port o_parity_err, output, 1 bit: one-cycle strobe on a parity mismatch.
REQ-011 SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 SHALL pass i_rx through a 2-flop synchronizer; all logic downstream uses only the synchronized value.
REQ-013 SHALL generate a sample tick every DIV = CLK_FREQ/(BAUD*OVERSAMPLE) clocks, integer-truncated (78 at defaults).
- Tick counter: 0..DIV-1; tick when the counter wraps.
- The counter reloads to 0 on the start-edge detect.
REQ-014 SHALL implement the states IDLE, START, DATA, PARITY (macro only), and STOP.
REQ-015 SHALL leave IDLE for START on a synchronized 1->0 transition only; a low level alone, such as a line held low after reset, SHALL NOT start a frame.
REQ-016 SHALL count OVERSAMPLE ticks per bit and decide each bit by majority of three samples.
- Samples taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- The decision is made at tick OVERSAMPLE/2+1.
REQ-017 SHALL, in START, return to IDLE with no strobe when the majority is 1 (false start).
REQ-018 SHALL shift 8 data bits LSB first in DATA, using a 3-bit bit counter that wraps after bit 7.
REQ-019 SHALL decide the STOP majority at mid-bit and then return to IDLE immediately, so a following start edge can be detected half a bit later.
REQ-020 SHALL, when the stop majority is 1 and no error is pending, load o_data and pulse o_valid for exactly 1 clk on the cycle after the decision.
REQ-021 SHALL, when the stop majority is 0, pulse o_frame_err for 1 clk, suppress o_valid, and hold o_data at its previous value.
REQ-022 SHALL hold o_data stable between o_valid strobes; no handshake is involved and the consumer must accept in the strobe cycle.
REQ-023 SHALL never assert o_valid together with o_frame_err or o_parity_err.
REQ-024 SHALL, after a frame error, require i_rx to go high before a new start edge is accepted; this is a consequence of REQ-015.

Reset
REQ-025 SHALL, while rst_n is low, force the following values:
- state IDLE; tick counter, sample counter and bit counter 0.
- synchronizer flops 1.
- o_data 8'h00; o_valid, o_frame_err, o_parity_err and o_busy 0.
REQ-026 SHALL discard any frame interrupted by reset and emit no strobe for it.

Configuration
REQ-027 SHALL use the macro UART_RX_PARITY_EN.
- Defined: a PARITY state follows DATA and checks even parity.
- On mismatch, the frame still runs through STOP; at the stop decision, o_parity_err pulses and o_valid is suppressed.
- When parity and stop are both bad, o_frame_err takes priority and o_parity_err stays 0.
REQ-028 SHALL, with UART_RX_PARITY_EN undefined, omit the PARITY state, keep the frame at 10 bits, and tie o_parity_err to 0 (port retained).

Verification
REQ-029 SHALL be verified with these directed scenarios at default parameters:
- Send 0x61, 8N1 at 9600 baud -> o_valid for 1 clk, o_data = 0x61, o_frame_err = 0; o_busy low within 1 bit after the stop mid-point.
- i_rx low for 300 clks, then high -> no o_valid or o_frame_err; state back to IDLE; o_busy 0 after about 1 bit time.
- Send 0x00 with the stop bit low -> o_frame_err for 1 clk, o_valid = 0, o_data keeps the previous 0x61; no new frame is accepted until i_rx returns high.
- Send 0x55 then 0xAA back-to-back with no idle gap -> two o_valid strobes in order, with o_data = 0x55 then 0xAA.
- Send 0x5A with a 1-clk low glitch on the centre sample of bit 2 -> o_data = 0x5A (majority vote rejects the glitch); then assert rst_n low during bit 3 of another frame -> all outputs 0; then send 0x7A -> o_data = 0x7A.
- With UART_RX_PARITY_EN defined: 0x41 with parity bit 0 -> o_valid, o_data = 0x41; 0x41 with parity bit 1 -> o_parity_err for 1 clk and no o_valid.
